// File: rtl/max_collector.sv
// Collects the maximum signed score from the last PE of a systolic chain,
// tracking the row/column where it first appeared, with a valid/ready result handshake.
module max_collector #(
  parameter int V_BIT   = 16,
  parameter int CNT_BIT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               lock,
  input  logic               start,
  input  logic [CNT_BIT-1:0] total,
  input  logic [V_BIT-1:0]   vIn,
  input  logic               newLineIn,
  output logic               busy,
  output logic               result_valid,
  input  logic               result_ready,
  output logic [V_BIT-1:0]   best,
  output logic [CNT_BIT-1:0] best_row,
  output logic [CNT_BIT-1:0] best_col
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_BIT-1:0] total_q, total_d;
  logic [CNT_BIT-1:0] sampleCnt_q, sampleCnt_d;
  logic [CNT_BIT-1:0] row_q, row_d;
  logic [CNT_BIT-1:0] col_q, col_d;
  logic [V_BIT-1:0]   best_q, best_d;
  logic [CNT_BIT-1:0] bestRow_q, bestRow_d;
  logic [CNT_BIT-1:0] bestCol_q, bestCol_d;

  logic               sample;
  logic [CNT_BIT-1:0] posRow;
  logic [CNT_BIT-1:0] posCol;
  logic [CNT_BIT-1:0] cntInc;

  // Position of the cell arriving this cycle; the first newLine of a run stays on row 0.
  always_comb begin
    posRow = row_q;
    posCol = col_q + CNT_BIT'(1);
    if (newLineIn) begin
      posRow = (sampleCnt_q == '0) ? '0 : row_q + CNT_BIT'(1);
      posCol = '0;
    end
  end

  assign sample = (state_q == RUN) && enable && !lock;
  assign cntInc = sampleCnt_q + CNT_BIT'(1);

  always_comb begin
    state_d     = state_q;
    total_d     = total_q;
    sampleCnt_d = sampleCnt_q;
    row_d       = row_q;
    col_d       = col_q;
    best_d      = best_q;
    bestRow_d   = bestRow_q;
    bestCol_d   = bestCol_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          total_d     = total;
          sampleCnt_d = '0;
          row_d       = '0;
          col_d       = '0;
          best_d      = '0;
          bestRow_d   = '0;
          bestCol_d   = '0;
          state_d     = (total == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (sample) begin
          row_d       = posRow;
          col_d       = posCol;
          sampleCnt_d = cntInc;
          // Strict compare: ties keep the earliest position.
          if ($signed(vIn) > $signed(best_q)) begin
            best_d    = vIn;
            bestRow_d = posRow;
            bestCol_d = posCol;
          end
          if (cntInc == total_q) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (result_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      total_q     <= '0;
      sampleCnt_q <= '0;
      row_q       <= '0;
      col_q       <= '0;
      best_q      <= '0;
      bestRow_q   <= '0;
      bestCol_q   <= '0;
    end else begin
      state_q     <= state_d;
      total_q     <= total_d;
      sampleCnt_q <= sampleCnt_d;
      row_q       <= row_d;
      col_q       <= col_d;
      best_q      <= best_d;
      bestRow_q   <= bestRow_d;
      bestCol_q   <= bestCol_d;
    end
  end

  assign busy         = (state_q == RUN);
  assign result_valid = (state_q == DONE);
  assign best         = best_q;
  assign best_row     = bestRow_q;
  assign best_col     = bestCol_q;

endmodule

// File: tb/tb_max_collector.sv
// Randomized and directed bench for max_collector; expected results come from
// a queue-based model that scans the accepted sample list.
module tb_max_collector;

  localparam int V_BIT   = 16;
  localparam int CNT_BIT = 16;

  logic               clk;
  logic               rst;
  logic               enable;
  logic               lock;
  logic               start;
  logic [CNT_BIT-1:0] total;
  logic [V_BIT-1:0]   vIn;
  logic               newLineIn;
  logic               busy;
  logic               result_valid;
  logic               result_ready;
  logic [V_BIT-1:0]   best;
  logic [CNT_BIT-1:0] best_row;
  logic [CNT_BIT-1:0] best_col;

  int compared   = 0;
  int mismatched = 0;

  int vq[$];
  bit nq[$];

  max_collector #(.V_BIT(V_BIT), .CNT_BIT(CNT_BIT)) dut (
    .clk(clk), .rst(rst), .enable(enable), .lock(lock), .start(start),
    .total(total), .vIn(vIn), .newLineIn(newLineIn), .busy(busy),
    .result_valid(result_valid), .result_ready(result_ready),
    .best(best), .best_row(best_row), .best_col(best_col)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: walk the accepted samples, tracking position and first strict maximum.
  task automatic computeExpected(output logic [V_BIT-1:0] eBest,
                                 output logic [CNT_BIT-1:0] eRow,
                                 output logic [CNT_BIT-1:0] eCol);
    int b, r, c, br, bc;
    b = 0; r = 0; c = 0; br = 0; bc = 0;
    for (int i = 0; i < vq.size(); i++) begin
      if (nq[i]) begin
        if (i == 0) r = 0;
        else        r = r + 1;
        c = 0;
      end else begin
        c = c + 1;
      end
      if (vq[i] > b) begin
        b = vq[i]; br = r; bc = c;
      end
    end
    eBest = V_BIT'(b);
    eRow  = CNT_BIT'(br);
    eCol  = CNT_BIT'(bc);
  endtask

  task automatic checkState(input string tag, input logic expValid, input logic expBusy,
                            input logic [V_BIT-1:0] eBest, input logic [CNT_BIT-1:0] eRow,
                            input logic [CNT_BIT-1:0] eCol);
    checkOutput({tag, ".valid"}, 32'(result_valid), 32'(expValid));
    checkOutput({tag, ".busy"},  32'(busy),         32'(expBusy));
    checkOutput({tag, ".best"},  32'(best),         32'(eBest));
    checkOutput({tag, ".row"},   32'(best_row),     32'(eRow));
    checkOutput({tag, ".col"},   32'(best_col),     32'(eCol));
  endtask

  // Runs the stream in vq/nq with random stalls, then exercises the result handshake.
  task automatic applyStimulus(input string tag, input int stallPct, input int holdCycles);
    logic [V_BIT-1:0]   eBest;
    logic [CNT_BIT-1:0] eRow, eCol;
    int n;
    n = vq.size();
    computeExpected(eBest, eRow, eCol);

    @(posedge clk); #1;
    start  = 1'b1;
    total  = CNT_BIT'(n);
    enable = 1'b1; lock = 1'b0;
    vIn    = 16'h7ABC; newLineIn = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;

    for (int i = 0; i < n; i++) begin
      int stalls;
      stalls = 0;
      while (stallPct > 0 && stalls < 6 && $urandom_range(99) < stallPct) begin
        if ($urandom_range(1) == 1) begin enable = 1'b1; lock = 1'b1; end
        else                        begin enable = 1'b0; lock = 1'b0; end
        vIn       = V_BIT'(16'h7000 + $urandom_range(255));
        newLineIn = 1'($urandom_range(1));
        @(posedge clk); #1;
        checkOutput({tag, ".stallBusy"}, 32'(busy), 32'd1);
        stalls++;
      end
      enable    = 1'b1;
      lock      = 1'b0;
      vIn       = V_BIT'(vq[i]);
      newLineIn = nq[i];
      start     = 1'($urandom_range(1));
      if (i == n - 1) checkOutput({tag, ".preValid"}, 32'(result_valid), 32'd0);
      @(posedge clk); #1;
      start = 1'b0;
    end

    checkState({tag, ".done"}, 1'b1, 1'b0, eBest, eRow, eCol);

    for (int j = 0; j < holdCycles; j++) begin
      enable = 1'b1; lock = 1'b0;
      vIn = 16'h7FFF; newLineIn = 1'($urandom_range(1));
      start = (j == 1);
      total = CNT_BIT'(3);
      @(posedge clk); #1;
      start = 1'b0;
      checkState({tag, ".hold"}, 1'b1, 1'b0, eBest, eRow, eCol);
    end

    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
    enable = 1'b0;
    checkState({tag, ".idle"}, 1'b0, 1'b0, eBest, eRow, eCol);
  endtask

  task automatic loadStream(input int vals[], input bit nls[]);
    vq.delete(); nq.delete();
    for (int i = 0; i < vals.size(); i++) begin
      vq.push_back(vals[i]);
      nq.push_back(nls[i]);
    end
  endtask

  initial begin
    rst = 1'b0; enable = 1'b0; lock = 1'b0; start = 1'b0;
    total = '0; vIn = '0; newLineIn = 1'b0; result_ready = 1'b0;

    @(posedge clk); #1;
    @(posedge clk); #1;
    checkState("reset", 1'b0, 1'b0, '0, '0, '0);
    rst = 1'b1;

    loadStream('{3, 7, 2, 7, 5, 1}, '{1, 0, 0, 1, 0, 0});
    applyStimulus("basic", 0, 1);
    applyStimulus("stall", 45, 10);

    loadStream('{0, -3, 0, -1}, '{1, 0, 0, 0});
    applyStimulus("negZero", 20, 2);

    vq.delete(); nq.delete();
    applyStimulus("totalZero", 0, 3);

    // Abort a run after three samples and confirm everything clears.
    @(posedge clk); #1;
    start = 1'b1; total = CNT_BIT'(6);
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      enable = 1'b1; lock = 1'b0; vIn = V_BIT'(100 + i); newLineIn = (i == 0);
      @(posedge clk); #1;
    end
    checkOutput("midRun.busy", 32'(busy), 32'd1);
    rst = 1'b0; start = 1'b1; result_ready = 1'b1;
    @(posedge clk); #1;
    checkState("midReset", 1'b0, 1'b0, '0, '0, '0);
    rst = 1'b1; start = 1'b0; result_ready = 1'b0; enable = 1'b0;
    @(posedge clk); #1;
    checkState("afterReset", 1'b0, 1'b0, '0, '0, '0);

    loadStream('{4, -2, 9, 9, 1, 3}, '{1, 0, 0, 1, 0, 1});
    applyStimulus("postReset", 10, 1);

    for (int r = 0; r < 20; r++) begin
      int n;
      n = 1 + $urandom_range(29);
      vq.delete(); nq.delete();
      for (int i = 0; i < n; i++) begin
        vq.push_back(int'($urandom_range(100)) - 50);
        nq.push_back((i == 0) ? 1'($urandom_range(3) != 0) : 1'($urandom_range(3) == 0));
      end
      applyStimulus($sformatf("rand%0d", r), 30, 1 + $urandom_range(4));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/max_collector.md
MAX_COLLECTOR -- requirements
Module: max_collector

Interface
REQ-001 SHALL have parameter V_BIT, default 16: score width; two's complement; equals the PE score width.
REQ-002 SHALL have parameter CNT_BIT, default 16: width of the sample, row and column counters.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port enable, input, 1: array enable, shared with the PE chain.
REQ-006 SHALL have port lock, input, 1: array stall, shared with the PE chain.
REQ-007 SHALL have port start, input, 1: one-cycle pulse that begins a run.
REQ-008 SHALL have port total, input, CNT_BIT: number of samples in the run; latched on accepted start.
REQ-009 SHALL have port vIn, input, V_BIT: score from the last PE (its vOut).
REQ-010 SHALL have port newLineIn, input, 1: newLineOut of the last PE; marks the first cell of a row.
REQ-011 SHALL have port busy, output, 1: high in RUN.
REQ-012 SHALL have port result_valid, output, 1: high in DONE.
REQ-013 SHALL have port result_ready, input, 1: consumer accepts the result.
REQ-014 SHALL have port best, output, V_BIT: maximum score of the run.
REQ-015 SHALL have port best_row, output, CNT_BIT: row index of best.
REQ-016 SHALL have port best_col, output, CNT_BIT: column index of best.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, DONE; reset state is IDLE.
REQ-018 SHALL go IDLE->RUN on start=1 and, in the same edge, latch total, set best=0, best_row=0, best_col=0, sample_cnt=0, row=0, col=0.
REQ-019 SHALL go IDLE->DONE directly when start=1 and total=0, with best, best_row and best_col all 0.
REQ-020 SHALL define a sample as a RUN-state cycle with enable=1 and lock=0; any other cycle SHALL leave all counters and results unchanged.
REQ-021 SHALL update position per sample as follows.
- newLineIn=1 and sample_cnt=0: row=0, col=0.
- newLineIn=1 and sample_cnt>0: row=row+1, col=0.
- newLineIn=0: col=col+1.
REQ-022 SHALL compute the current position in REQ-021 combinationally and use it for the same-cycle best_row/best_col capture.
REQ-023 SHALL update best, best_row and best_col on a sample only when signed vIn > best (strict); ties keep the earliest position, and negative scores never update.
REQ-024 SHALL increment sample_cnt by one per sample, and go RUN->DONE on the edge where the incremented count equals the latched total; that final sample is included in the result.
REQ-025 SHALL hold best, best_row and best_col stable while result_valid=1.
REQ-026 SHALL go DONE->IDLE on result_ready=1; result_valid drops on the next cycle.
REQ-027 SHALL keep best, best_row and best_col at their last values in IDLE until the next accepted start.
REQ-028 SHALL ignore start in RUN and DONE.
REQ-029 SHALL let counters wrap modulo 2^CNT_BIT without error indication.
REQ-030 SHALL have a combinational path of one signed comparator plus counter increment, with registered outputs only; result latency is 1 cycle after the final sample.

Reset
REQ-031 SHALL, when rst=0 at a clock edge, force state=IDLE, busy=0, result_valid=0, best=0, best_row=0, best_col=0, sample_cnt=0, row=0, col=0, and latched total=0.
REQ-032 SHALL apply REQ-031 from any state, including mid-RUN and DONE, and discard partial results.
REQ-033 SHALL give rst priority over start and result_ready in the same cycle.

Verification
REQ-034 Basic run: total=6, samples vIn=3,7,2,7,5,1, newLineIn=1 on samples 0 and 3 -> result_valid one cycle after sample 5; best=7, best_row=0, best_col=1 (tie at row 1 col 0 not taken).
REQ-035 Stall: same stream with lock=1 for 4 cycles and enable=0 for 2 cycles interleaved -> identical result; sample_cnt frozen during stalls.
REQ-036 Handshake: hold result_ready=0 for 10 cycles in DONE -> result_valid and outputs stable; result_ready=1 -> IDLE next cycle; start pulsed during DONE has no effect.
REQ-037 All-zero and negative: total=4, vIn=0,-3,0,-1 -> best=0, best_row=0, best_col=0; total=0 with start -> DONE immediately with all outputs 0.
REQ-038 Reset mid-run: rst=0 after 3 of 6 samples -> all outputs 0 and IDLE next cycle; a new run then gives a correct result unaffected by earlier data.
